j17_sequencer: RTL

Multi-cycle instruction sequencer for the J17 core. It steps each instruction through fetch, decode, execute and writeback and drives the cycle-by-cycle enables of the datapath: instruction-memory request, IR load, ALU, register file and PC. It runs alongside the combinational control unit. That unit decodes *what* an opcode does; this block decides *when* each datapath enable fires. The block also evaluates conditional jumps, handles HLT and illegal opcodes, detects fetch timeouts and keeps a retired-instruction count.

---
 rtl/j17_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/j17_sequencer.sv
// j17_sequencer: multi-cycle fetch/decode/execute/writeback sequencer for the
// J17 core. It decides *when* the datapath enables fire; the combinational
// control unit decides *what* each opcode does. Also evaluates conditional
// jumps, traps HLT / illegal opcodes, watches for fetch timeouts and counts
// retired instructions.
module j17_sequencer #(
   parameter int COUNT_W       = 16,
   parameter int FETCH_TIMEOUT = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic [5:0]         opcode,
   input  logic               zf,
   input  logic               cf,
   input  logic               imem_ack,
   output logic               imem_req,
   output logic               ir_load,
   output logic               alu_en,
   output logic               regenable,
   output logic               pc_inc,
   output logic               pc_load,
   output logic               halted,
   output logic               fault,
   output logic               illegal,
   output logic [COUNT_W-1:0] retired,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      WRITEBACK = 3'd3,
      BRANCH    = 3'd4,
      HALT      = 3'd5
   } state_t;

   // Opcode map
   localparam logic [5:0] OP_ALU_LAST = 6'd14;
   localparam logic [5:0] OP_JMP      = 6'd15;
   localparam logic [5:0] OP_JE       = 6'd16;
   localparam logic [5:0] OP_JB       = 6'd17;
   localparam logic [5:0] OP_JA       = 6'd18;
   localparam logic [5:0] OP_JNE      = 6'd19;
   localparam logic [5:0] OP_JBE      = 6'd20;
   localparam logic [5:0] OP_JAE      = 6'd21;
   localparam logic [5:0] OP_JZ       = 6'd22;
   localparam logic [5:0] OP_JNZ      = 6'd23;
   localparam logic [5:0] OP_MOV      = 6'd24;
   localparam logic [5:0] OP_NOP      = 6'd25;
   localparam logic [5:0] OP_HLT      = 6'd26;

   // The wait counter holds the number of unanswered request cycles already
   // completed; the request cycle that would make it FETCH_TIMEOUT is the
   // last one allowed, and an ack in that same cycle still wins.
   localparam logic [7:0]         WAIT_LAST   = 8'(FETCH_TIMEOUT - 1);
   localparam logic [COUNT_W-1:0] RETIRED_MAX = '1;
   localparam logic [COUNT_W-1:0] RETIRED_ONE = COUNT_W'(1);

   state_t               cur_state;
   state_t               nxt_state;
   logic                 req_q;
   logic                 req_d;
   logic [7:0]           wait_cnt;
   logic [7:0]           wait_d;
   logic                 fault_q;
   logic                 fault_d;
   logic [COUNT_W-1:0]   retired_q;

   function automatic logic is_alu_op(input logic [5:0] op);
      return (op <= OP_ALU_LAST) || (op == OP_MOV);
   endfunction

   function automatic logic is_jump_op(input logic [5:0] op);
      return (op >= OP_JMP) && (op <= OP_JNZ);
   endfunction

   // Branch condition from the flags the ALU left behind after compare.
   function automatic logic jump_taken(input logic [5:0] op, input logic z, input logic c);
      logic t;
      t = 1'b0;
      case (op)
         OP_JMP:        t = 1'b1;
         OP_JE, OP_JZ:  t = z;
         OP_JNE, OP_JNZ: t = ~z;
         OP_JB:         t = c;
         OP_JAE:        t = ~c;
         OP_JA:         t = ~c & ~z;
         OP_JBE:        t = c | z;
         default:       t = 1'b0;
      endcase
      return t;
   endfunction

   // State, fetch request, timeout counter and sticky fault registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur_state <= FETCH;
         req_q     <= 1'b0;
         wait_cnt  <= 8'd0;
         fault_q   <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         req_q     <= req_d;
         wait_cnt  <= wait_d;
         fault_q   <= fault_d;
      end
   end

   // Next-state logic and per-state datapath strobes. Every path that returns
   // to FETCH pre-arms the request from run, so back-to-back instructions
   // need no idle cycle when run stays high.
   always_comb begin
      nxt_state = cur_state;
      req_d     = req_q;
      wait_d    = wait_cnt;
      fault_d   = fault_q;
      ir_load   = 1'b0;
      alu_en    = 1'b0;
      regenable = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
      case (cur_state)
         FETCH: begin
            if (req_q) begin
               if (imem_ack) begin
                  ir_load   = 1'b1;
                  req_d     = 1'b0;
                  wait_d    = 8'd0;
                  nxt_state = DECODE;
               end else if (wait_cnt == WAIT_LAST) begin
                  fault_d   = 1'b1;
                  req_d     = 1'b0;
                  wait_d    = 8'd0;
                  nxt_state = HALT;
               end else begin
                  wait_d    = wait_cnt + 8'd1;
               end
            end else begin
               // Acks without an outstanding request are ignored here.
               req_d = run;
            end
         end
         DECODE: begin
            if (is_alu_op(opcode)) begin
               nxt_state = EXECUTE;
            end else if (is_jump_op(opcode)) begin
               nxt_state = BRANCH;
            end else if (opcode == OP_NOP) begin
               pc_inc    = 1'b1;
               req_d     = run;
               nxt_state = FETCH;
            end else if (opcode == OP_HLT) begin
               nxt_state = HALT;
            end else begin
               pc_inc    = 1'b1;
               illegal   = 1'b1;
               req_d     = run;
               nxt_state = FETCH;
            end
         end
         EXECUTE: begin
            alu_en    = 1'b1;
            nxt_state = WRITEBACK;
         end
         WRITEBACK: begin
            regenable = 1'b1;
            pc_inc    = 1'b1;
            req_d     = run;
            nxt_state = FETCH;
         end
         BRANCH: begin
            if (jump_taken(opcode, zf, cf)) begin
               pc_load = 1'b1;
            end else begin
               pc_inc  = 1'b1;
            end
            req_d     = run;
            nxt_state = FETCH;
         end
         HALT: begin
            halted = 1'b1;
            req_d  = 1'b0;
         end
         default: begin
            req_d     = 1'b0;
            nxt_state = FETCH;
         end
      endcase
   end

   // Retired-instruction counter: one per PC update, saturating at all-ones.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         retired_q <= '0;
      end else if ((pc_inc || pc_load) && (retired_q != RETIRED_MAX)) begin
         retired_q <= retired_q + RETIRED_ONE;
      end
   end

   assign imem_req = req_q;
   assign fault    = fault_q;
   assign retired  = retired_q;
   assign state    = cur_state;

endmodule
